gen_rst_seq: RTL and testbench
==============================

# gen_rst_seq

Parametrised power-on reset sequencer: holds every downstream reset for a fixed interval after the board reset releases, then releases `CH_NUM` reset channels in a staged order with a programmable gap between them. Supports a global soft re-trigger and independent per-channel soft resets once running. It sits at the top of the clock/reset tree next to the clock generation logic and drives the reset inputs of the functional subsystems (tuner I/F, TS processing, QAM, DDR, etc.).

## Interface
- `SIMULATION`, "FALSE", "TRUE" selects the short simulation timing constants below.
- `CH_NUM`, 4, number of reset channels, 1..16.
- `HOLD_CYCLES`, (SIMULATION=="FALSE") ? 300000 : 100, global hold time in `clk` cycles, ≥1.
- `STAGE_GAP`, (SIMULATION=="FALSE") ? 1000 : 10, cycles between successive channel releases, ≥1.
- `CH_HOLD`, (SIMULATION=="FALSE") ? 3000 : 20, per-channel soft-reset pulse length, ≥1.
- `CNT_W`, 24, counter width; must hold max(HOLD_CYCLES, STAGE_GAP, CH_HOLD).

- `clk` input 1 system clock.
- `rst_i` input 1 synchronous, active-low reset.
- `soft_rst_all` input 1 level/pulse; restarts the full sequence.
- `soft_rst_ch` input CH_NUM per-channel soft reset request, bit i -> channel i.
- `rst_o` output CH_NUM active-high channel resets.
- `rst_done` output 1 high when all channels are released and none is in soft reset.
- `busy` output 1 high while in HOLD or STAGE.

## Operation
- FSM states: HOLD, STAGE, RUN.
- Reset (`rst_i`=0 at a `clk` edge): state HOLD, main counter 0, stage index 0, `rst_o` all 1, `rst_done` 0, `busy` 1, all channel counters 0.
- HOLD: counter increments each cycle; when counter == HOLD_CYCLES-1: counter cleared, `rst_o[0]` cleared, state -> STAGE (or RUN if CH_NUM==1).
- STAGE: counter increments; when counter == STAGE_GAP-1: counter cleared, stage index k+1, `rst_o[k+1]` cleared. The edge that clears `rst_o[CH_NUM-1]` also enters RUN.
- RUN: `busy` 0; `rst_done` = 1 when no channel soft reset is active.
- `soft_rst_ch[i]` sampled high in RUN: `rst_o[i]` set on the next edge and held for exactly CH_HOLD cycles. A re-request while active reloads the count. Any number of channels may be active simultaneously. Ignored in HOLD/STAGE.
- `soft_rst_all` sampled high in any state: next edge sets all `rst_o`, clears the counter, stage index and channel counters, and enters HOLD. Held high, it keeps the sequencer at HOLD count 0. It has priority over `soft_rst_ch`.
- `rst_i` low overrides everything, including mid-sequence and mid-soft-reset.

## Timing
- First edge with `rst_i`=1 is cycle 1. `rst_o[0]` falls at the end of cycle HOLD_CYCLES, so it is high for exactly HOLD_CYCLES cycles.
- `rst_o[k]` falls at HOLD_CYCLES + k·STAGE_GAP. `rst_done` rises and `busy` falls on the same edge as `rst_o[CH_NUM-1]` falls.
- Soft channel reset latency: request edge +1 to rise. `rst_done` falls on that same edge and rises on the edge `rst_o[i]` falls.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `GEN_RST_SEQ_STAGED_EN` defined: staged release as above.
- Not defined: STAGE state and stage-gap logic are compiled out. All `rst_o` bits, `rst_done` and `busy` change together at the end of cycle HOLD_CYCLES. `STAGE_GAP` is unused.

## Test plan
All scenarios run with SIMULATION="TRUE", CH_NUM=4 (HOLD 100, GAP 10, CH_HOLD 20), macro defined unless stated.
- Power-on: `rst_i` low 5 cycles then high -> `rst_o[0..3]` fall at cycles 100/110/120/130. `rst_done` rises and `busy` falls at 130.
- Macro undefined: same stimulus -> all four `rst_o` and `rst_done` change at cycle 100.
- Per-channel soft reset: `soft_rst_ch`=4'b0100 for 1 cycle in RUN -> `rst_o[2]` high for 20 cycles, `rst_done` low for those 20 cycles. A re-pulse at the 10th cycle extends the high time to 30 cycles total.
- Simultaneous events: `soft_rst_all` and `soft_rst_ch`=4'b1111 in the same cycle during RUN -> full re-sequence. `rst_o[0]` falls 100 cycles later and the channel requests have no effect.
- Mid-sequence abort: `soft_rst_all` pulsed at cycle 115 (channel 0 and channel 1 released) -> all `rst_o` high next edge, `rst_o[0]` falls 100 cycles later.
- Reset mid-operation: `rst_i` low for 1 cycle during a channel soft reset -> all outputs return to reset values and the full power-on timing repeats.

Source files
------------

// File: rtl/gen_rst_seq.sv
// gen_rst_seq -- power-on reset sequencer.
//
// Holds every downstream reset for HOLD_CYCLES after the board reset
// releases. It then releases CH_NUM reset channels one at a time, STAGE_GAP
// cycles apart. Once running, any channel can be pulsed back into reset for
// CH_HOLD cycles. soft_rst_all restarts the whole sequence.
//
// Build option: define GEN_RST_SEQ_STAGED_EN for staged release. Without it,
// all channels release together at the end of the hold interval.
//
// Ports:
//   clk          system clock
//   rst_i        synchronous active-low reset
//   soft_rst_all restart the full sequence (dominates soft_rst_ch)
//   soft_rst_ch  per-channel soft reset request, honoured only in RUN
//   rst_o        active-high channel resets (registered)
//   rst_done     all channels released, none in soft reset (registered)
//   busy         sequencer in HOLD or STAGE (registered)

// Per-channel soft-reset timer. act_nxt is the channel's reset state after
// the coming edge, so the top level can register rst_o/rst_done from it.
module gen_rst_seq_ch #(
  parameter int CNT_W   = 24,
  parameter int CH_HOLD = 20
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr,
  input  logic req,
  output logic act_nxt
);
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // A request (re)loads the full pulse length; the channel is active while
  // the count is non-zero, so the pulse is exactly CH_HOLD edges long.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)              cnt_nxt = '0;
    else if (req)         cnt_nxt = CNT_W'(CH_HOLD);
    else if (cnt != '0)   cnt_nxt = cnt - 1'b1;
  end

  assign act_nxt = (cnt_nxt != '0);

  always_ff @(posedge clk) begin
    if (!rst_i) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
endmodule

module gen_rst_seq #(
  parameter string SIMULATION  = "FALSE",
  parameter int    CH_NUM      = 4,
  parameter int    HOLD_CYCLES = (SIMULATION == "FALSE") ? 300000 : 100,
  parameter int    STAGE_GAP   = (SIMULATION == "FALSE") ? 1000 : 10,
  parameter int    CH_HOLD     = (SIMULATION == "FALSE") ? 3000 : 20,
  parameter int    CNT_W       = 24
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              soft_rst_all,
  input  logic [CH_NUM-1:0] soft_rst_ch,
  output logic [CH_NUM-1:0] rst_o,
  output logic              rst_done,
  output logic              busy
);
  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP)
                         ? ((HOLD_CYCLES > CH_HOLD) ? HOLD_CYCLES : CH_HOLD)
                         : ((STAGE_GAP > CH_HOLD) ? STAGE_GAP : CH_HOLD);

  if (CH_NUM < 1 || CH_NUM > 16 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
      CH_HOLD < 1 || (CNT_W < 32 && (MAX_CNT >> CNT_W) != 0)) begin : g_bad_cfg
    $error("gen_rst_seq: illegal parameter set");
  end

`ifdef GEN_RST_SEQ_STAGED_EN
  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  typedef enum logic [1:0] {HOLD, STAGE, RUN} state_t;
  logic [IDX_W-1:0] idx, idx_nxt;
`else
  typedef enum logic [1:0] {HOLD, RUN} state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CH_NUM-1:0] ch_act_nxt;
  logic [CH_NUM-1:0] rst_o_nxt;
  logic              rst_done_nxt;
  logic              busy_nxt;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    gen_rst_seq_ch #(.CNT_W(CNT_W), .CH_HOLD(CH_HOLD)) u_ch (
      .clk     (clk),
      .rst_i   (rst_i),
      .clr     (soft_rst_all),
      .req     (soft_rst_ch[i] && state == RUN),
      .act_nxt (ch_act_nxt[i])
    );
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef GEN_RST_SEQ_STAGED_EN
    idx_nxt   = idx;
`endif
    case (state)
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_nxt = '0;
`ifdef GEN_RST_SEQ_STAGED_EN
          idx_nxt   = '0;
          state_nxt = (CH_NUM == 1) ? RUN : STAGE;
`else
          state_nxt = RUN;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef GEN_RST_SEQ_STAGED_EN
      STAGE: begin
        if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          cnt_nxt = '0;
          idx_nxt = idx + IDX_W'(1);
          // Releasing the last channel ends the sequence.
          if (int'(idx) == CH_NUM - 2) state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      default: ;
    endcase

    if (soft_rst_all) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
`ifdef GEN_RST_SEQ_STAGED_EN
      idx_nxt   = '0;
`endif
    end

    // During STAGE, idx is the highest channel already released.
    for (int i = 0; i < CH_NUM; i++) begin
      rst_o_nxt[i] = ch_act_nxt[i] || state_nxt == HOLD;
`ifdef GEN_RST_SEQ_STAGED_EN
      if (state_nxt == STAGE && i > int'(idx_nxt)) rst_o_nxt[i] = 1'b1;
`endif
    end

    rst_done_nxt = (state_nxt == RUN) && !(|ch_act_nxt);
    busy_nxt     = (state_nxt != RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state    <= HOLD;
      cnt      <= '0;
`ifdef GEN_RST_SEQ_STAGED_EN
      idx      <= '0;
`endif
      rst_o    <= '1;
      rst_done <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
`ifdef GEN_RST_SEQ_STAGED_EN
      idx      <= idx_nxt;
`endif
      rst_o    <= rst_o_nxt;
      rst_done <= rst_done_nxt;
      busy     <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_gen_rst_seq.sv
// Self-checking bench for gen_rst_seq (SIMULATION="TRUE", CH_NUM=4).
// Directed table and corner sequences check against constants. A timing
// model checks every cycle; it works from event times (last restart edge
// and per-channel soft-reset end times).
module tb_gen_rst_seq;
  localparam int CH   = 4;
  localparam int HOLD = 100;
  localparam int GAP  = 10;
  localparam int CHH  = 20;
`ifdef GEN_RST_SEQ_STAGED_EN
  localparam int STEP = GAP;
`else
  localparam int STEP = 0;
`endif
  localparam int LAST = HOLD + (CH - 1) * STEP;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          soft_rst_all = 1'b0;
  logic [CH-1:0] soft_rst_ch = '0;
  logic [CH-1:0] rst_o;
  logic          rst_done;
  logic          busy;

  gen_rst_seq #(.SIMULATION("TRUE"), .CH_NUM(CH)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .soft_rst_all (soft_rst_all),
    .soft_rst_ch  (soft_rst_ch),
    .rst_o        (rst_o),
    .rst_done     (rst_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edge count, edge of last restart, end edge of each soft pulse.
  int cyc = 0;
  int start = 0;
  int until_e [CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit running(input int n);
    return (n - start) >= LAST;
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic a, input logic [CH-1:0] ch);
    logic          was_run;
    logic [CH-1:0] e_o;
    bit            any;
    rst_i = r; soft_rst_all = a; soft_rst_ch = ch;
    @(posedge clk);
    cyc++;
    was_run = running(cyc - 1);
    if (!r || a) begin
      start = cyc;
      for (int i = 0; i < CH; i++) until_e[i] = 0;
    end else if (was_run) begin
      for (int i = 0; i < CH; i++) if (ch[i]) until_e[i] = cyc + CHH;
    end
    #1;
    any = 0;
    for (int i = 0; i < CH; i++) begin
      e_o[i] = ((cyc - start) < HOLD + i * STEP) || (cyc < until_e[i]);
      if (cyc < until_e[i]) any = 1;
    end
    chk("model_rst_o", rst_o, e_o);
    chk("model_rst_done", rst_done, running(cyc) && !any);
    chk("model_busy", busy, !running(cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic chk_out(input string nm, input logic [CH-1:0] eo, input logic ed, input logic eb);
    chk({nm, "_rst_o"}, rst_o, eo);
    chk({nm, "_rst_done"}, rst_done, ed);
    chk({nm, "_busy"}, busy, eb);
  endtask

  typedef struct {
    logic          r;
    logic          a;
    logic [CH-1:0] ch;
    int            n;
    logic [CH-1:0] eo;
    logic          ed;
    logic          eb;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a, input logic [CH-1:0] ch,
                              input int n, input logic [CH-1:0] eo, input logic ed,
                              input logic eb);
    vec_t v;
    v.r = r; v.a = a; v.ch = ch; v.n = n; v.eo = eo; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    logic [CH-1:0] e100, e110, e120;
    logic          d100;
`ifdef GEN_RST_SEQ_STAGED_EN
    e100 = 4'b1110; e110 = 4'b1100; e120 = 4'b1000; d100 = 1'b0;
`else
    e100 = 4'b0000; e110 = 4'b0000; e120 = 4'b0000; d100 = 1'b1;
`endif
    tbl[0]  = mk(0, 0, 4'b0000,  5, 4'b1111, 0, 1);
    tbl[1]  = mk(1, 0, 4'b0000, 99, 4'b1111, 0, 1);
    tbl[2]  = mk(1, 0, 4'b0000,  1, e100, d100, !d100);
    tbl[3]  = mk(1, 0, 4'b0000,  9, e100, d100, !d100);
    tbl[4]  = mk(1, 0, 4'b0000,  1, e110, d100, !d100);
    tbl[5]  = mk(1, 0, 4'b0000, 10, e120, d100, !d100);
    tbl[6]  = mk(1, 0, 4'b0000, 10, 4'b0000, 1, 0);
    tbl[7]  = mk(1, 0, 4'b0000, 10, 4'b0000, 1, 0);
    tbl[8]  = mk(1, 0, 4'b0100,  1, 4'b0100, 0, 0);
    tbl[9]  = mk(1, 0, 4'b0000, 19, 4'b0100, 0, 0);
    tbl[10] = mk(1, 0, 4'b0000,  1, 4'b0000, 1, 0);

    // Power-on staging, then a single channel soft reset.
    for (int t = 0; t < 11; t++) begin
      for (int k = 0; k < tbl[t].n; k++) step(tbl[t].r, tbl[t].a, tbl[t].ch);
      chk_out($sformatf("tbl%0d", t), tbl[t].eo, tbl[t].ed, tbl[t].eb);
    end

    // Re-pulse 10 cycles in extends the pulse to 30 cycles.
    step(1, 0, 4'b0100);
    idle(9);
    step(1, 0, 4'b0100);
    idle(19);
    chk_out("repulse_hi", 4'b0100, 0, 0);
    idle(1);
    chk_out("repulse_lo", 4'b0000, 1, 0);

    // soft_rst_all together with every channel request.
    step(1, 1, 4'b1111);
    chk_out("all_sim", 4'b1111, 0, 1);
    idle(99);
    chk_out("all_sim_99", 4'b1111, 0, 1);
    idle(1);
    chk_out("all_sim_100", e100, d100, !d100);

    // Abort mid-sequence at cycle 115.
    step(0, 0, 4'b0000);
    idle(114);
    chk_out("abort_114", e110, d100, !d100);
    step(1, 1, 4'b0000);
    chk_out("abort", 4'b1111, 0, 1);
    idle(99);
    chk_out("abort_99", 4'b1111, 0, 1);
    idle(1);
    chk_out("abort_100", e100, d100, !d100);

    // Board reset during a channel soft reset.
    idle(40);
    step(1, 0, 4'b0010);
    chk_out("mid_soft", 4'b0010, 0, 0);
    idle(5);
    step(0, 0, 4'b0000);
    chk_out("mid_rst", 4'b1111, 0, 1);
    idle(99);
    chk_out("mid_rst_99", 4'b1111, 0, 1);
    idle(1);
    chk_out("mid_rst_100", e100, d100, !d100);
    idle(40);

    // Random traffic against the timing model.
    for (int t = 0; t < 4000; t++) begin
      logic          r, a;
      logic [CH-1:0] ch;
      r = ($urandom_range(599) != 0);
      a = ($urandom_range(399) == 0);
      for (int i = 0; i < CH; i++) ch[i] = ($urandom_range(29) == 0);
      step(r, a, ch);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
